pipe_ctrl: RTL and testbench

Pipeline control block for the five-stage MIPS32 core. It arbitrates the single shared memory bus between instruction fetch (IF) and data access (MEM), and runs a bus watchdog. It merges per-stage stall requests into the `stall[5:0]` vector consumed by `pc_reg`, `if_id`, `id_ex`, `ex_mem` and `mem_wb`. It also sequences exception flushes, so that a flush never cuts an in-flight bus transfer.

---
 rtl/pipe_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: shared memory-bus arbiter (MEM over IF), bus watchdog,
// stall-vector merge and exception flush sequencing for the 5-stage core.
module pipe_ctrl #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic        mem_req,
    input  logic        bus_ack,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        exc_valid,
    input  logic [31:0] exc_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        bus_grant_if,
    output logic        bus_grant_mem,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_XFER  = 2'd1,
        MEM_XFER = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WD_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    state_t                state_reg, state_next;
    logic [TIMEOUT_W-1:0]  wd_reg, wd_next, wd_inc;
    logic                  exc_pend_reg, exc_pend_next;
    logic [31:0]           exc_pc_q_reg, exc_pc_q_next;

    logic in_xfer, xfer_ack, wd_expire;
    logic exc_take, exc_now, exc_defer;
    logic mem_wait, if_wait;

    // Grants come straight from the state register, so reset drops them at once.
    assign bus_grant_if  = (state_reg == IF_XFER);
    assign bus_grant_mem = (state_reg == MEM_XFER);

    assign in_xfer  = bus_grant_if | bus_grant_mem;
    assign xfer_ack = in_xfer & bus_ack;

    // wd_reg holds the cycles already spent in the transfer; wd_inc counts the
    // current one too, so the abort lands on grant cycle 2^TIMEOUT_W-1.
    assign wd_inc    = wd_reg + WD_ONE;
    assign wd_expire = in_xfer & ~bus_ack & (&wd_inc);

    // Only the first exception is taken; later ones are dropped until FLUSH.
    // A flush may only happen when no transfer would be cut short.
    assign exc_take  = rst & exc_valid & ~exc_pend_reg;
    assign exc_now   = exc_take & ((state_reg == IDLE) | xfer_ack);
    assign exc_defer = exc_take & ~exc_now;

    assign mem_wait = mem_req & ~(bus_grant_mem & bus_ack);
    assign if_wait  = if_req  & ~(bus_grant_if  & bus_ack);

    // State, watchdog and pending-exception registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            wd_reg       <= '0;
            exc_pend_reg <= 1'b0;
            exc_pc_q_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wd_reg       <= wd_next;
            exc_pend_reg <= exc_pend_next;
            exc_pc_q_reg <= exc_pc_q_next;
        end
    end

    // Next-state, watchdog, flush and bus-error logic.
    always_comb begin
        state_next    = state_reg;
        wd_next       = wd_reg;
        exc_pend_next = exc_pend_reg;
        exc_pc_q_next = exc_pc_q_reg;
        flush         = 1'b0;
        new_pc        = '0;
        bus_err       = 1'b0;

        case (state_reg)
            IDLE: begin
                wd_next = '0;
                if (exc_pend_reg) begin
                    state_next = FLUSH;
                end else if (exc_now) begin
                    // Immediate flush; no grant is issued this cycle.
                    flush      = 1'b1;
                    new_pc     = exc_pc;
                    state_next = IDLE;
                end else if (mem_req) begin
                    state_next = MEM_XFER;
                end else if (if_req) begin
                    state_next = IF_XFER;
                end
            end
            IF_XFER, MEM_XFER: begin
                wd_next = wd_inc;
                if (bus_ack) begin
                    wd_next    = '0;
                    state_next = exc_pend_reg ? FLUSH : IDLE;
                    if (exc_now) begin
                        flush  = 1'b1;
                        new_pc = exc_pc;
                    end
                end else if (wd_expire) begin
                    wd_next    = '0;
                    bus_err    = 1'b1;
                    state_next = IDLE;
                end
            end
            FLUSH: begin
                flush         = 1'b1;
                new_pc        = exc_pc_q_reg;
                exc_pend_next = 1'b0;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (exc_defer) begin
            exc_pend_next = 1'b1;
            exc_pc_q_next = exc_pc;
        end
    end

    // Stall vector merge, highest-priority source first.
    always_comb begin
        stall = 6'b000000;
        if (!rst || flush)                  stall = 6'b000000;
        else if (exc_pend_reg || exc_defer) stall = 6'b111111;
        else if (mem_wait)                  stall = 6'b011111;
        else if (stallreq_ex)               stall = 6'b001111;
        else if (stallreq_id)               stall = 6'b000111;
        else if (if_wait)                   stall = 6'b000011;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl (TIMEOUT_W=3): inputs change 1 ns after
// the rising edge, outputs are checked at the falling edge.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        if_req, mem_req, bus_ack;
    logic        stallreq_id, stallreq_ex;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        bus_grant_if, bus_grant_mem, bus_err;

    int n_checks = 0;
    int n_errors = 0;

    pipe_ctrl #(.TIMEOUT_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .mem_req      (mem_req),
        .bus_ack      (bus_ack),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .exc_valid    (exc_valid),
        .exc_pc       (exc_pc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .bus_grant_if (bus_grant_if),
        .bus_grant_mem(bus_grant_mem),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    initial begin
        rst = 1'b0; if_req = 0; mem_req = 0; bus_ack = 0;
        stallreq_id = 0; stallreq_ex = 0; exc_valid = 0; exc_pc = '0;

        // Reset holds every output low, even with requests present.
        #2;
        mem_req = 1; exc_valid = 1; exc_pc = 32'h1234;
        #1;
        check_val("rst_stall",    32'(stall), 32'h00);
        check_val("rst_flush",    32'(flush), 32'h0);
        check_val("rst_new_pc",   new_pc, 32'h0);
        check_val("rst_grant_m",  32'(bus_grant_mem), 32'h0);
        check_val("rst_grant_i",  32'(bus_grant_if), 32'h0);
        check_val("rst_bus_err",  32'(bus_err), 32'h0);
        mem_req = 0; exc_valid = 0; exc_pc = '0;

        // Release reset with idle inputs.
        tick(); rst = 1; settle();
        check_val("idle_stall",   32'(stall), 32'h00);
        check_val("idle_grants",  32'({bus_grant_mem, bus_grant_if}), 32'h0);

        // Simultaneous IF/MEM requests: MEM wins, IF follows after one IDLE cycle.
        tick(); if_req = 1; mem_req = 1; settle();
        check_val("arb_req_grant_m", 32'(bus_grant_mem), 32'h0);
        check_val("arb_req_stall",   32'(stall), 32'h1f);
        tick(); settle();
        check_val("arb_g1_grant_m", 32'(bus_grant_mem), 32'h1);
        check_val("arb_g1_grant_i", 32'(bus_grant_if), 32'h0);
        check_val("arb_g1_stall",   32'(stall), 32'h1f);
        tick(); bus_ack = 1; settle();
        check_val("arb_g2_grant_m", 32'(bus_grant_mem), 32'h1);
        check_val("arb_g2_stall",   32'(stall), 32'h03);
        tick(); bus_ack = 0; mem_req = 0; settle();
        check_val("arb_gap_grants", 32'({bus_grant_mem, bus_grant_if}), 32'h0);
        check_val("arb_gap_stall",  32'(stall), 32'h03);
        tick(); settle();
        check_val("arb_if1_grant_i", 32'(bus_grant_if), 32'h1);
        check_val("arb_if1_stall",   32'(stall), 32'h03);
        tick(); bus_ack = 1; settle();
        check_val("arb_if2_stall",   32'(stall), 32'h00);
        tick(); bus_ack = 0; if_req = 0; settle();
        check_val("arb_done_grant_i", 32'(bus_grant_if), 32'h0);

        // Stall request merge.
        tick(); stallreq_id = 1; stallreq_ex = 1; settle();
        check_val("merge_id_ex", 32'(stall), 32'h0f);
        tick(); stallreq_ex = 0; settle();
        check_val("merge_id", 32'(stall), 32'h07);
        tick(); stallreq_id = 0; settle();

        // Immediate flush in IDLE; the concurrent MEM request is not granted.
        tick(); exc_valid = 1; exc_pc = 32'h20; mem_req = 1; settle();
        check_val("imm_flush",  32'(flush), 32'h1);
        check_val("imm_new_pc", new_pc, 32'h20);
        check_val("imm_stall",  32'(stall), 32'h00);
        tick(); exc_valid = 0; exc_pc = '0; mem_req = 0; settle();
        check_val("imm_no_grant", 32'(bus_grant_mem), 32'h0);
        check_val("imm_flush_end", 32'(flush), 32'h0);
        check_val("imm_pc_end", new_pc, 32'h0);

        // Exception during a MEM transfer is held until the ack.
        tick(); mem_req = 1; settle();
        tick(); exc_valid = 1; exc_pc = 32'h40; settle();
        check_val("pend_g1_grant", 32'(bus_grant_mem), 32'h1);
        check_val("pend_g1_stall", 32'(stall), 32'h3f);
        check_val("pend_g1_flush", 32'(flush), 32'h0);
        tick(); exc_valid = 0; exc_pc = '0; settle();
        check_val("pend_g2_stall", 32'(stall), 32'h3f);
        tick(); exc_valid = 1; exc_pc = 32'h80; settle();
        check_val("pend_g3_stall", 32'(stall), 32'h3f);
        check_val("pend_g3_flush", 32'(flush), 32'h0);
        tick(); exc_valid = 0; exc_pc = '0; bus_ack = 1; settle();
        check_val("pend_ack_stall", 32'(stall), 32'h3f);
        check_val("pend_ack_flush", 32'(flush), 32'h0);
        tick(); bus_ack = 0; mem_req = 0; settle();
        check_val("pend_flush",  32'(flush), 32'h1);
        check_val("pend_new_pc", new_pc, 32'h40);
        check_val("pend_stall",  32'(stall), 32'h00);
        check_val("pend_grant",  32'(bus_grant_mem), 32'h0);
        tick(); settle();
        check_val("pend_after_flush",  32'(flush), 32'h0);
        check_val("pend_after_new_pc", new_pc, 32'h0);

        // Exception on the ack cycle flushes immediately.
        tick(); mem_req = 1; settle();
        tick(); bus_ack = 1; exc_valid = 1; exc_pc = 32'h100; settle();
        check_val("ackexc_flush",  32'(flush), 32'h1);
        check_val("ackexc_new_pc", new_pc, 32'h100);
        check_val("ackexc_stall",  32'(stall), 32'h00);
        tick(); bus_ack = 0; exc_valid = 0; exc_pc = '0; mem_req = 0; settle();
        check_val("ackexc_after_flush", 32'(flush), 32'h0);
        check_val("ackexc_after_grant", 32'(bus_grant_mem), 32'h0);

        // Watchdog: no ack, abort on grant cycle 7.
        tick(); mem_req = 1; settle();
        for (int k = 1; k <= 7; k++) begin
            tick(); settle();
            check_val($sformatf("wd_c%0d_grant", k), 32'(bus_grant_mem), 32'h1);
            check_val($sformatf("wd_c%0d_err", k), 32'(bus_err), (k == 7) ? 32'h1 : 32'h0);
            check_val($sformatf("wd_c%0d_stall", k), 32'(stall), 32'h1f);
        end
        tick(); settle();
        check_val("wd_post_grant", 32'(bus_grant_mem), 32'h0);
        check_val("wd_post_err",   32'(bus_err), 32'h0);
        check_val("wd_post_stall", 32'(stall), 32'h1f);

        // Reset mid-transfer drops the grant without a clock edge.
        tick(); settle();
        check_val("midrst_pre_grant", 32'(bus_grant_mem), 32'h1);
        #1; rst = 0; #1;
        check_val("midrst_grant", 32'(bus_grant_mem), 32'h0);
        check_val("midrst_stall", 32'(stall), 32'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
